pulse_peak_extractor: RTL
=========================

// Module: pulse_peak_extractor
//
// PURPOSE
//  Consumes the shaped sample stream from the trapezoidal shaping filter and reduces
//  each pulse to one event record: peak amplitude, peak timestamp and width.
//  Sits downstream of the filter, one sample per in_valid.
//  Drives a valid/ready event port toward readout logic.
//  Threshold FSM with hold-off; single-entry output register with sticky overflow.
//
// PARAMETERS
//  THRESHOLD  100  signed trigger level; a pulse is active while in_data > THRESHOLD (strict)
//  MIN_WIDTH  2    minimum pulse width in samples; shorter pulses are discarded
//  HOLDOFF    8    valid samples ignored after an emitted event; 0 = no hold-off
//  TS_W       32   timestamp counter width
//  WID_W      16   width counter width
//
// PORTS
//  clk        in   1                   clock
//  reset      in   1                   synchronous, active-low
//  in_data    in   SIZE_FILTER_DATA+1  filter output, signed two's complement
//  in_valid   in   1                   in_data valid this cycle
//  evt_valid  out  1                   event record valid
//  evt_ready  in   1                   consumer accepts record
//  evt_amp    out  SIZE_FILTER_DATA+1  peak amplitude, signed
//  evt_time   out  TS_W                sample index of the first peak sample
//  evt_width  out  WID_W               samples above threshold, saturating
//  busy       out  1                   FSM not in IDLE
//  overflow   out  1                   sticky: an event was dropped
//
// BEHAVIOUR
//  Reset (reset == 0 at posedge): all outputs 0, ts = 0, FSM = IDLE, event register empty.
//  Reset mid-pulse abandons the pulse; no event is emitted.
//  Timestamp ts:
//   - Increments by 1 on every in_valid cycle and wraps modulo 2^TS_W.
//   - The sample arriving with in_valid carries the pre-increment value of ts.
//  Cycles with in_valid = 0 change no FSM state or counters.
//  FSM states:
//   - IDLE: sample > THRESHOLD -> PULSE; load amp = sample, ptime = ts, width = 1.
//   - PULSE, sample > THRESHOLD:
//     - width += 1, saturating at 2^WID_W - 1.
//     - If sample > amp, load amp = sample and ptime = ts.
//     - Equal values do not move ptime (first maximum wins).
//   - PULSE, sample <= THRESHOLD:
//     - width >= MIN_WIDTH: emit the event, then go to HOLDOFF (or IDLE if HOLDOFF == 0).
//     - Otherwise discard the pulse and go to IDLE.
//   - HOLDOFF: counts HOLDOFF valid samples with all samples ignored, then IDLE.
//     - A sample above threshold on the last hold-off sample is also ignored.
//  Emit latency: evt_valid rises the cycle after the terminating sub-threshold sample.
//  Output handshake:
//   - A transfer occurs on any cycle with evt_valid && evt_ready.
//   - evt_amp, evt_time and evt_width are stable while evt_valid && !evt_ready.
//   - On emit, the register is loaded when it is empty or being transferred in the same
//     cycle, giving back-to-back throughput.
//   - If the register is full and not being transferred, the new event is dropped and
//     overflow is set; the held record is unchanged.
//   - overflow is cleared only by reset.
//  Arithmetic: all comparisons are signed. Negative undershoot never triggers.
//
// TESTING
//  1. Pulse 0,50,150,300,200,120,90 (THRESHOLD 100), evt_ready = 1 ->
//     one event: amp = 300, time = 3, width = 4; evt_valid rises the cycle after the 90.
//  2. Samples 0,150,0 with MIN_WIDTH = 2 -> no event, overflow = 0, FSM back in IDLE.
//  3. Plateau 200,250,250,250 then 0 -> amp = 250, time = index of the first 250.
//  4. Two qualifying pulses with evt_ready held 0 -> first record held stable,
//     second dropped, overflow = 1 until reset.
//  5. Pulse reaching threshold 3 samples after emit, HOLDOFF = 8 -> ignored;
//     the same pulse after hold-off expires -> event emitted.
//  6. reset asserted mid-PULSE; TS_W = 4 run past 15 ->
//     - no event and all outputs 0 after reset;
//     - evt_time wraps 15 -> 0 correctly.

Source files
------------

// File: rtl/pulse_peak_extractor.sv
// Reduces each above-threshold pulse of the shaped stream to one {amp, time, width}
// record, with post-event hold-off and a single-entry output register.
module pulse_peak_extractor #(
  parameter int SIZE_FILTER_DATA = 15,
  parameter int THRESHOLD        = 100,
  parameter int MIN_WIDTH        = 2,
  parameter int HOLDOFF          = 8,
  parameter int TS_W             = 32,
  parameter int WID_W            = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [SIZE_FILTER_DATA:0] in_data,
  input  logic                          in_valid,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic signed [SIZE_FILTER_DATA:0] evt_amp,
  output logic [TS_W-1:0]               evt_time,
  output logic [WID_W-1:0]              evt_width,
  output logic                          busy,
  output logic                          overflow
);
  localparam int DW   = SIZE_FILTER_DATA + 1;
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic signed [DW-1:0] TH      = DW'(THRESHOLD);
  localparam logic [WID_W-1:0]     WID_MAX = '1;

  typedef struct packed {
    logic signed [DW-1:0] amp;
    logic [TS_W-1:0]      ptime;
    logic [WID_W-1:0]     width;
  } evt_t;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t          state, state_nxt;
  evt_t            cur, cur_nxt, rec;
  logic [TS_W-1:0] ts;
  logic [HC_W-1:0] hcnt, hcnt_nxt;
  logic            above, emit;

  assign above = in_data > TH;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    hcnt_nxt  = hcnt;
    emit      = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (above) begin
            state_nxt = PULSE;
            cur_nxt   = '{amp: in_data, ptime: ts, width: WID_W'(1)};
          end
        end
        PULSE: begin
          if (above) begin
            if (cur.width != WID_MAX) cur_nxt.width = cur.width + 1'b1;
            // strict compare: on a plateau the first maximum keeps its timestamp
            if (in_data > cur.amp) begin
              cur_nxt.amp   = in_data;
              cur_nxt.ptime = ts;
            end
          end else if (cur.width >= WID_W'(MIN_WIDTH)) begin
            emit      = 1'b1;
            state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
            hcnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
        HOLD: begin
          if (hcnt == HC_W'(HOLDOFF - 1)) state_nxt = IDLE;
          else                            hcnt_nxt  = hcnt + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur       <= '0;
      hcnt      <= '0;
      ts        <= '0;
      rec       <= '0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cur  <= cur_nxt;
      hcnt <= hcnt_nxt;
      if (in_valid) ts <= ts + 1'b1;
      // a slot being drained this cycle can take the new record immediately
      if (emit && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        rec       <= cur;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (emit && evt_valid && !evt_ready) overflow <= 1'b1;
    end
  end

  assign evt_amp   = rec.amp;
  assign evt_time  = rec.ptime;
  assign evt_width = rec.width;
  assign busy      = (state != IDLE);

endmodule
